// File: rtl/exu_regfile_pkg.sv
// Shared defaults and write-classification helpers for the execution-unit register file.
// The top module and its flop sub-module both import these definitions.
package exu_regfile_pkg;

   localparam int XLEN_DFLT        = 32;
   localparam int RFIDX_WIDTH_DFLT = 5;
   localparam int RFREG_NUM_DFLT   = 32;
   localparam int X10_IDX          = 10;

   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,
      WB_ZERO   = 2'd1,
      WB_RANGE  = 2'd2,
      WB_COMMIT = 2'd3
   } wb_kind_e;

   // Reset dominates; x0 and indices past the implemented file are dropped.
   function automatic wb_kind_e wb_classify(input logic rst_n, input logic ena,
                                            input int unsigned idx, input int unsigned num);
      wb_kind_e kind;
      if (!rst_n || !ena) begin
         kind = WB_IDLE;
      end else if (idx == 32'd0) begin
         kind = WB_ZERO;
      end else if (idx >= num) begin
         kind = WB_RANGE;
      end else begin
         kind = WB_COMMIT;
      end
      return kind;
   endfunction

   function automatic logic rd_idx_ok(input int unsigned idx, input int unsigned num);
      return (idx != 32'd0) && (idx < num);
   endfunction

endpackage

// File: rtl/exu_regfile_gnrl_dfflr.sv
// Generic load-enable flop with synchronous active-low clear to zero.
// Used for every register entry and for the write counter.
module gnrl_dfflr #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   logic [DW-1:0] q_r;

   // State update: clear dominates load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_r <= {DW{1'b0}};
      end else if (lden) begin
         q_r <= dnxt;
      end else begin
         q_r <= q_r;
      end
   end

   assign qout = q_r;

endmodule

// File: rtl/exu_regfile.sv
// Integer register file: x0 hard-wired to zero, write-first bypass on both read
// ports, registered x10 debug view and a committed-write counter.
module exu_regfile
   import exu_regfile_pkg::*;
#(
   parameter int XLEN        = XLEN_DFLT,
   parameter int RFIDX_WIDTH = RFIDX_WIDTH_DFLT,
   parameter int RFREG_NUM   = RFREG_NUM_DFLT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rf_wbck_ena,
   input  logic [RFIDX_WIDTH-1:0] rf_wbck_rdidx,
   input  logic [XLEN-1:0]        rf_wbck_wdat,
   input  logic [RFIDX_WIDTH-1:0] read_src1_idx,
   input  logic [RFIDX_WIDTH-1:0] read_src2_idx,
   output logic [XLEN-1:0]        read_src1_dat,
   output logic [XLEN-1:0]        read_src2_dat,
   output logic [XLEN-1:0]        dbg_x10_dat,
   output logic [31:0]            wr_cnt
);

   localparam int AW = $clog2(RFREG_NUM);

   wb_kind_e        wb_kind_s;
   logic            wb_commit_s;
   logic            byp1_s;
   logic            byp2_s;
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;
   logic [XLEN-1:0] dbg_s;
   logic [31:0]     wr_cnt_r;
   logic [31:0]     wr_cnt_nxt_s;
   logic [XLEN-1:0] rf_q_s [0:RFREG_NUM-1];

   // Classify the writeback request.
   always_comb begin
      wb_kind_s = wb_classify(rst_n, rf_wbck_ena, 32'(rf_wbck_rdidx), RFREG_NUM);
   end

   // Only a committed write updates state, bypasses or counts.
   always_comb begin
      case (wb_kind_s)
         WB_COMMIT: wb_commit_s = 1'b1;
         WB_IDLE:   wb_commit_s = 1'b0;
         WB_ZERO:   wb_commit_s = 1'b0;
         WB_RANGE:  wb_commit_s = 1'b0;
         default:   wb_commit_s = 1'b0;
      endcase
   end

   assign rf_q_s[0] = {XLEN{1'b0}};

   genvar i;
   generate
      for (i = 1; i < RFREG_NUM; i++) begin : g_entry
         logic lden_s;
         assign lden_s = wb_commit_s && (rf_wbck_rdidx == RFIDX_WIDTH'(i));
         gnrl_dfflr #(.DW(XLEN)) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .lden  (lden_s),
            .dnxt  (rf_wbck_wdat),
            .qout  (rf_q_s[i])
         );
      end
   endgenerate

   // Bypass only when the in-flight write is committed to the same index.
   always_comb begin
      byp1_s = wb_commit_s && (read_src1_idx == rf_wbck_rdidx);
      byp2_s = wb_commit_s && (read_src2_idx == rf_wbck_rdidx);
   end

   // Source-1 read mux; outputs stay zero while reset is held.
   always_comb begin
      rd1_s = {XLEN{1'b0}};
      if (!rst_n) begin
         rd1_s = {XLEN{1'b0}};
      end else if (!rd_idx_ok(32'(read_src1_idx), RFREG_NUM)) begin
         rd1_s = {XLEN{1'b0}};
      end else if (byp1_s) begin
         rd1_s = rf_wbck_wdat;
      end else begin
         rd1_s = rf_q_s[read_src1_idx[AW-1:0]];
      end
   end

   // Source-2 read mux, independent of source 1.
   always_comb begin
      rd2_s = {XLEN{1'b0}};
      if (!rst_n) begin
         rd2_s = {XLEN{1'b0}};
      end else if (!rd_idx_ok(32'(read_src2_idx), RFREG_NUM)) begin
         rd2_s = {XLEN{1'b0}};
      end else if (byp2_s) begin
         rd2_s = rf_wbck_wdat;
      end else begin
         rd2_s = rf_q_s[read_src2_idx[AW-1:0]];
      end
   end

   // Debug view of the stored a0 value, never bypassed.
   always_comb begin
      dbg_s = {XLEN{1'b0}};
      if (!rst_n) begin
         dbg_s = {XLEN{1'b0}};
      end else begin
         dbg_s = rf_q_s[X10_IDX];
      end
   end

   assign wr_cnt_nxt_s = wr_cnt_r + 32'd1;

   gnrl_dfflr #(.DW(32)) u_wr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (wb_commit_s),
      .dnxt  (wr_cnt_nxt_s),
      .qout  (wr_cnt_r)
   );

   assign read_src1_dat = rd1_s;
   assign read_src2_dat = rd2_s;
   assign dbg_x10_dat   = dbg_s;
   assign wr_cnt        = wr_cnt_r;

endmodule

// File: tb/tb_exu_regfile.sv
// Bench for exu_regfile: directed vector table on a 32-entry build, then random
// traffic on 32- and 16-entry builds against an array-based reference model.
module tb_exu_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [4:0]  rdidx;
   logic [31:0] wdat;
   logic [4:0]  s1;
   logic [4:0]  s2;
   logic [31:0] a_r1, a_r2, a_dbg, a_cnt;
   logic [31:0] b_r1, b_r2, b_dbg, b_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   exu_regfile #(.XLEN(32), .RFIDX_WIDTH(5), .RFREG_NUM(32)) dut (
      .clk(clk), .rst_n(rst_n), .rf_wbck_ena(ena), .rf_wbck_rdidx(rdidx),
      .rf_wbck_wdat(wdat), .read_src1_idx(s1), .read_src2_idx(s2),
      .read_src1_dat(a_r1), .read_src2_dat(a_r2), .dbg_x10_dat(a_dbg), .wr_cnt(a_cnt)
   );

   exu_regfile #(.XLEN(32), .RFIDX_WIDTH(5), .RFREG_NUM(16)) dut_e (
      .clk(clk), .rst_n(rst_n), .rf_wbck_ena(ena), .rf_wbck_rdidx(rdidx),
      .rf_wbck_wdat(wdat), .read_src1_idx(s1), .read_src2_idx(s2),
      .read_src1_dat(b_r1), .read_src2_dat(b_r2), .dbg_x10_dat(b_dbg), .wr_cnt(b_cnt)
   );

   typedef struct {
      logic        rst_n;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] edbg;
      logic [31:0] ecnt;
   } vec_t;

   vec_t vt [13];

   // Reference model: index 0 = 32-entry build, index 1 = 16-entry build.
   logic [31:0] mem [2][32];
   logic [31:0] cnt [2];
   int          nums [2] = '{32, 16};

   function automatic logic [31:0] exp_rd(int d, logic [4:0] idx);
      if (!rst_n) return 32'd0;
      if (idx == 5'd0 || int'(idx) >= nums[d]) return 32'd0;
      if (ena && rdidx == idx) return wdat;
      return mem[d][idx];
   endfunction

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            for (int k = 0; k < 32; k++) mem[d][k] = 32'd0;
            cnt[d] = 32'd0;
         end else if (ena && rdidx != 5'd0 && int'(rdidx) < nums[d]) begin
            mem[d][rdidx] = wdat;
            cnt[d] = cnt[d] + 32'd1;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, expv);
      end
   endtask

   task automatic drive(logic r, logic e, logic [4:0] rd, logic [31:0] wd,
                        logic [4:0] i1, logic [4:0] i2);
      @(negedge clk);
      rst_n = r; ena = e; rdidx = rd; wdat = wd; s1 = i1; s2 = i2;
      #1;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_edge();
   endtask

   initial begin
      vt[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h0,        32'h0,        32'h0, 32'd0};
      vt[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'h0, 32'd0};
      vt[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0, 32'd1};
      vt[3]  = '{1'b1, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0, 32'd1};
      vt[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0, 32'd1};
      vt[5]  = '{1'b1, 1'b1, 5'd7,  32'h1,        5'd7,  5'd0,  32'h1,        32'h0,        32'h0, 32'd1};
      vt[6]  = '{1'b1, 1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'd2};
      vt[7]  = '{1'b1, 1'b1, 5'd10, 32'h1,        5'd7,  5'd10, 32'hA5A5A5A5, 32'h1,        32'h0, 32'd3};
      vt[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd10, 5'd7,  32'h1,        32'hA5A5A5A5, 32'h1, 32'd4};
      vt[9]  = '{1'b1, 1'b1, 5'd3,  32'hFFFFFFFF, 5'd3,  5'd10, 32'hFFFFFFFF, 32'h1,        32'h1, 32'd4};
      vt[10] = '{1'b0, 1'b1, 5'd4,  32'h11111111, 5'd3,  5'd4,  32'h0,        32'h0,        32'h0, 32'd5};
      vt[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h0,        32'h0,        32'h0, 32'd0};
      vt[12] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd10, 5'd5,  32'h0,        32'h0,        32'h0, 32'd0};

      rst_n = 1'b0; ena = 1'b0; rdidx = 5'd0; wdat = 32'd0; s1 = 5'd0; s2 = 5'd0;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      finish_cycle();

      for (int v = 0; v < 13; v++) begin
         drive(vt[v].rst_n, vt[v].ena, vt[v].rd, vt[v].wd, vt[v].s1, vt[v].s2);
         chk($sformatf("vec%0d_src1", v), a_r1, vt[v].e1);
         chk($sformatf("vec%0d_src2", v), a_r2, vt[v].e2);
         chk($sformatf("vec%0d_x10", v), a_dbg, vt[v].edbg);
         chk($sformatf("vec%0d_wrcnt", v), a_cnt, vt[v].ecnt);
         finish_cycle();
      end

      // Writes above x15 must be dropped by the 16-entry build only.
      drive(1'b1, 1'b1, 5'd20, 32'hCAFEF00D, 5'd20, 5'd20);
      chk("e32_hi_bypass", a_r1, 32'hCAFEF00D);
      chk("e16_hi_bypass", b_r1, 32'h0);
      finish_cycle();
      drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd20, 5'd15);
      chk("e32_hi_read", a_r1, 32'hCAFEF00D);
      chk("e16_hi_read", b_r1, 32'h0);
      chk("e16_hi_cnt", b_cnt, cnt[1]);
      finish_cycle();

      for (int n = 0; n < 500; n++) begin
         logic        r;
         logic        e;
         logic [4:0]  rd;
         logic [4:0]  i1;
         logic [4:0]  i2;
         r  = ($urandom_range(0, 39) != 0);
         e  = ($urandom_range(0, 3) != 0);
         rd = 5'($urandom_range(0, 31));
         i1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         i2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         drive(r, e, rd, $urandom, i1, i2);
         chk("rnd32_src1", a_r1, exp_rd(0, s1));
         chk("rnd32_src2", a_r2, exp_rd(0, s2));
         chk("rnd32_x10", a_dbg, rst_n ? mem[0][10] : 32'd0);
         chk("rnd32_wrcnt", a_cnt, cnt[0]);
         chk("rnd16_src1", b_r1, exp_rd(1, s1));
         chk("rnd16_src2", b_r2, exp_rd(1, s2));
         chk("rnd16_x10", b_dbg, rst_n ? mem[1][10] : 32'd0);
         chk("rnd16_wrcnt", b_cnt, cnt[1]);
         finish_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
